data_memory: RTL and testbench



---
 rtl/data_memory.sv | 49 ++++
 tb/tb_data_memory.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
`timescale 1ns/1ps
// data_memory: word-addressed 16-bit data memory for the MEM stage of the
// 16-bit MIPS datapath. Synchronous write, combinational read, async clear.
module data_memory #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] datain,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [15:0] dataout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;
  logic [15:0]   mem [DEPTH];

  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  assign idx = addr[AW-1:0];

  generate
    if (AW < 16) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^addr[15:AW];
    end
  endgenerate

  // Reset clears every word immediately; writes only when out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 16'h0000;
      end
    end else if (MemWrite) begin
      mem[idx] <= datain;
    end
  end

  always_comb begin
    dataout = 16'h0000;
    if (MemRead) begin
      dataout = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
`timescale 1ns/1ps
// tb_data_memory: scoreboard bench for data_memory; stimulus pushes expected
// read values, a monitor pops and compares them against dataout.
module tb_data_memory;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] datain;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] dataout;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .datain   (datain),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .dataout  (dataout)
  );

  logic [15:0] refMem [DEPTH];
  logic [15:0] expQ [$];
  string       nameQ [$];
  logic        checkStrobe;
  int          checks;
  int          errors;
  logic [15:0] burstAddr [$];

  initial clk = 1'b0;
  always #1 clk = ~clk;

  function automatic logic [15:0] modelRead(input logic [15:0] a, input logic re);
    if (!re) return 16'h0000;
    return refMem[int'(a) % DEPTH];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) refMem[i] = 16'h0000;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d,
                               input logic we, input logic re);
    addr     = a;
    datain   = d;
    MemWrite = we;
    MemRead  = re;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    expQ.push_back(exp);
    nameQ.push_back(name);
    checkStrobe = 1'b1;
    #0.2;
    checkStrobe = 1'b0;
    #0.1;
  endtask

  task automatic writeCycle(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    applyStimulus(a, d, 1'b1, 1'b0);
    @(posedge clk);
    if (rst_n) refMem[int'(a) % DEPTH] = d;
  endtask

  task automatic readCheck(input string name, input logic [15:0] a);
    @(negedge clk);
    applyStimulus(a, 16'h0000, 1'b0, 1'b1);
    #0.1;
    checkOutput(name, modelRead(a, 1'b1));
  endtask

  // Monitor: every strobe consumes one expected value from the scoreboard.
  initial begin
    forever begin
      @(posedge checkStrobe);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_underflow: dataout=%h with no expected value", dataout);
      end else begin
        automatic logic [15:0] exp = expQ.pop_front();
        automatic string nm = nameQ.pop_front();
        if (dataout !== exp) begin
          errors++;
          $display("[TB] FAIL %s: dataout=%h expected=%h (addr=%h)", nm, dataout, exp, addr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] a, d;
    logic we, re;
    checks = 0;
    errors = 0;
    checkStrobe = 1'b0;
    modelClear();
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1);
    rst_n = 1'b0;

    // Reset clear
    #1.5;
    checkOutput("reset_dataout", 16'h0000);
    #1.2;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) readCheck("reset_sweep", 16'(k));

    // Sequential fill and readback
    for (int k = 0; k < 16; k++) writeCycle(16'(k), 16'(k + 1));
    readCheck("fill_rd5", 16'd5);
    readCheck("fill_rd3", 16'd3);
    readCheck("fill_rd11", 16'd11);
    readCheck("fill_rd15", 16'd15);
    readCheck("fill_rd0", 16'd0);
    @(negedge clk);
    applyStimulus(16'd5, 16'h0000, 1'b0, 1'b0);
    #0.1;
    checkOutput("memread_off", 16'h0000);

    // Read-during-write
    @(negedge clk);
    applyStimulus(16'd7, 16'hBEEF, 1'b1, 1'b1);
    #0.1;
    checkOutput("rdw_before", 16'd8);
    @(posedge clk);
    refMem[7] = 16'hBEEF;
    #0.1;
    checkOutput("rdw_after", 16'hBEEF);

    // Write gating
    @(negedge clk);
    applyStimulus(16'd4, 16'h1234, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    readCheck("write_gated", 16'd4);
    if (refMem[4] != 16'd5) $display("[TB] note: model word 4 is %h", refMem[4]);

    // Aliasing
    writeCycle(16'h0102, 16'hA5A5);
    readCheck("alias_0002", 16'h0002);
    readCheck("alias_ff02", 16'hFF02);

    // Randomised traffic, checked before and after each edge
    for (int n = 0; n < 200; n++) begin
      a  = 16'(($urandom() & 32'hFF00) | $urandom_range(0, 31));
      d  = 16'($urandom());
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      @(negedge clk);
      applyStimulus(a, d, we, re);
      #0.1;
      checkOutput("rand_pre", modelRead(a, re));
      @(posedge clk);
      if (we) refMem[int'(a) % DEPTH] = d;
      #0.1;
      checkOutput("rand_post", modelRead(a, re));
    end

    // Reset in the middle of a write burst
    for (int n = 0; n < 6; n++) begin
      a = 16'(32 + n * 3);
      burstAddr.push_back(a);
      writeCycle(a, 16'(16'hC000 + n + 1));
    end
    @(negedge clk);
    applyStimulus(burstAddr[5], 16'h7777, 1'b1, 1'b1);
    #0.1;
    checkOutput("burst_pre_reset", modelRead(burstAddr[5], 1'b1));
    rst_n = 1'b0;
    modelClear();
    #0.1;
    checkOutput("reset_async", 16'h0000);
    @(posedge clk);
    #0.1;
    checkOutput("reset_write_blocked", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    MemWrite = 1'b0;
    for (int n = 0; n < 6; n++) readCheck("post_reset_burst", burstAddr[n]);
    for (int k = 0; k < DEPTH; k += 17) readCheck("post_reset_sweep", 16'(k));

    #2;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
